// File: rtl/nes_controller_poller.sv
// nes_controller_poller: polls shared-latch NES/SNES pads with detection, auto-poll and edge reporting
module nes_controller_poller #(
    parameter int NUM_CONTROLLERS   = 4,
    parameter int DATA_BITS         = 8,
    parameter int LATCH_PULSE_WIDTH = 2,
    parameter int CLK_HALF_PERIOD   = 1,
    parameter int AUTO_POLL_PERIOD  = 0,
    parameter int DETECT            = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_fetch_i,
    output logic                                 busy_o,
    output logic                                 valid_o,
    output logic                                 controller_clk_o,
    output logic                                 controller_latch_o,
    input  logic [NUM_CONTROLLERS-1:0]           controller_serial_LIST_ni,
    output logic [NUM_CONTROLLERS*DATA_BITS-1:0] data_LIST_o,
    output logic [NUM_CONTROLLERS-1:0]           connected_o,
    output logic [NUM_CONTROLLERS*DATA_BITS-1:0] pressed_LIST_o,
    output logic [NUM_CONTROLLERS*DATA_BITS-1:0] released_LIST_o
);
    localparam int N  = DATA_BITS + DETECT;
    localparam int PW = $clog2((LATCH_PULSE_WIDTH > CLK_HALF_PERIOD ? LATCH_PULSE_WIDTH : CLK_HALF_PERIOD) + 1);
    localparam int SW = $clog2(N + 1);
    localparam int AW = AUTO_POLL_PERIOD > 1 ? $clog2(AUTO_POLL_PERIOD) : 1;
    localparam logic [AW-1:0] AP_MAX = AW'(AUTO_POLL_PERIOD > 0 ? AUTO_POLL_PERIOD - 1 : 0);
    localparam logic [PW-1:0] L_MAX  = PW'(LATCH_PULSE_WIDTH - 1);
    localparam logic [PW-1:0] H_MAX  = PW'(CLK_HALF_PERIOD - 1);
    localparam logic [SW-1:0] N_CNT  = SW'(N);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        LATCH = 5'b00010,
        LOW   = 5'b00100,
        HIGH  = 5'b01000,
        DONE  = 5'b10000
    } state_t;

    state_t state, state_nx;
    logic [PW-1:0] phase;
    logic [SW-1:0] samples;
    logic [AW-1:0] ap_cnt;
    logic tick, launch, phase_end, sample, commit;
    logic [N-1:0] shift [NUM_CONTROLLERS];
    logic [NUM_CONTROLLERS*DATA_BITS-1:0] new_data;
    logic [NUM_CONTROLLERS-1:0] new_conn;

    assign tick      = AUTO_POLL_PERIOD != 0 && ap_cnt == AP_MAX;
    assign launch    = state == IDLE && (start_fetch_i || tick);
    assign phase_end = phase == (state == LATCH ? L_MAX : H_MAX);
    assign sample    = state == LOW && phase_end;
    assign commit    = state == HIGH && phase_end && samples == N_CNT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE  ? (launch ? LATCH : IDLE)
                 : state == LATCH ? (phase_end ? LOW : LATCH)
                 : state == LOW   ? (phase_end ? HIGH : LOW)
                 : state == HIGH  ? (phase_end ? (samples == N_CNT ? DONE : LOW) : HIGH)
                 : IDLE;
    end

    always_comb begin
        busy_o             = state != IDLE;
        valid_o            = state == DONE;
        controller_latch_o = state == LATCH;
        controller_clk_o   = state == HIGH;
    end

    // Phase counter restarts on every state change; auto-poll counter restarts on every launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= '0;
            samples <= '0;
            ap_cnt  <= '0;
        end else begin
            phase   <= state_nx != state ? '0 : phase + PW'(1);
            samples <= launch ? '0 : samples + SW'(sample);
            ap_cnt  <= (launch || tick) ? '0 : ap_cnt + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CONTROLLERS; i++) shift[i] <= '0;
        end else if (sample) begin
            for (int i = 0; i < NUM_CONTROLLERS; i++) shift[i] <= {shift[i][N-2:0], ~controller_serial_LIST_ni[i]};
        end
    end

    // The trailing detect bit lands in bit 0; an absent port reads as all released.
    always_comb begin
        new_conn = '0;
        new_data = '0;
        for (int i = 0; i < NUM_CONTROLLERS; i++) begin
            new_conn[i] = DETECT != 0 ? shift[i][0] : 1'b1;
            new_data[i*DATA_BITS +: DATA_BITS] = new_conn[i] ? shift[i][N-1 -: DATA_BITS] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_LIST_o     <= '0;
            connected_o     <= '0;
            pressed_LIST_o  <= '0;
            released_LIST_o <= '0;
        end else if (commit) begin
            data_LIST_o     <= new_data;
            connected_o     <= new_conn;
            pressed_LIST_o  <= new_data & ~data_LIST_o;
            released_LIST_o <= ~new_data & data_LIST_o;
        end
    end
endmodule

// File: tb/tb_nes_controller_poller.sv
// tb_nes_controller_poller: scoreboard bench with behavioural pads for NES, SNES and auto-poll builds
module tb_nes_controller_poller;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Default NES build
    logic start_a = 0, busy_a, valid_a, cclk_a, latch_a;
    logic [3:0] ser_a, conn_a;
    logic [31:0] data_a, pr_a, rl_a;
    nes_controller_poller dut_a (
        .clk(clk), .rst(rst), .start_fetch_i(start_a), .busy_o(busy_a), .valid_o(valid_a),
        .controller_clk_o(cclk_a), .controller_latch_o(latch_a), .controller_serial_LIST_ni(ser_a),
        .data_LIST_o(data_a), .connected_o(conn_a), .pressed_LIST_o(pr_a), .released_LIST_o(rl_a)
    );

    // SNES build with slow pad clock
    logic start_b = 0, busy_b, valid_b, cclk_b, latch_b;
    logic [3:0] ser_b, conn_b;
    logic [63:0] data_b, pr_b, rl_b;
    nes_controller_poller #(.DATA_BITS(16), .CLK_HALF_PERIOD(3)) dut_b (
        .clk(clk), .rst(rst), .start_fetch_i(start_b), .busy_o(busy_b), .valid_o(valid_b),
        .controller_clk_o(cclk_b), .controller_latch_o(latch_b), .controller_serial_LIST_ni(ser_b),
        .data_LIST_o(data_b), .connected_o(conn_b), .pressed_LIST_o(pr_b), .released_LIST_o(rl_b)
    );

    // Auto-polling build with every port empty
    logic start_c = 0, busy_c, valid_c, cclk_c, latch_c;
    logic [3:0] ser_c = 4'hF, conn_c;
    logic [31:0] data_c, pr_c, rl_c;
    nes_controller_poller #(.AUTO_POLL_PERIOD(50)) dut_c (
        .clk(clk), .rst(rst), .start_fetch_i(start_c), .busy_o(busy_c), .valid_o(valid_c),
        .controller_clk_o(cclk_c), .controller_latch_o(latch_c), .controller_serial_LIST_ni(ser_c),
        .data_LIST_o(data_c), .connected_o(conn_c), .pressed_LIST_o(pr_c), .released_LIST_o(rl_c)
    );

    // Pad models: load on latch, shift on rising pad clock, then shift out "pressed" (serial low)
    logic [8:0] sh_a [4];
    logic [31:0] btn_a = 0;
    logic [3:0] pres_a = 0;
    always @(posedge latch_a or posedge cclk_a)
        for (int i = 0; i < 4; i++) sh_a[i] <= latch_a ? {btn_a[i*8 +: 8], 1'b1} : {sh_a[i][7:0], 1'b1};
    always_comb begin
        ser_a = '1;
        for (int i = 0; i < 4; i++) ser_a[i] = pres_a[i] ? ~sh_a[i][8] : 1'b1;
    end

    logic [16:0] sh_b [4];
    logic [63:0] btn_b = 0;
    logic [3:0] pres_b = 4'hF;
    always @(posedge latch_b or posedge cclk_b)
        for (int i = 0; i < 4; i++) sh_b[i] <= latch_b ? {btn_b[i*16 +: 16], 1'b1} : {sh_b[i][15:0], 1'b1};
    always_comb begin
        ser_b = '1;
        for (int i = 0; i < 4; i++) ser_b[i] = pres_b[i] ? ~sh_b[i][16] : 1'b1;
    end

    typedef struct {
        logic [31:0] d, p, r;
        logic [3:0] c;
        int t;
    } exp_t;
    exp_t sb[$];
    logic [31:0] prev_a = 0;
    logic busy_chk = 0;

    always @(negedge clk) begin
        exp_t e;
        if (busy_chk) check("busy_fall", busy_a, 0);
        busy_chk = 0;
        if (valid_a) begin
            if (sb.size() == 0) check("valid_spurious", valid_a, 0);
            else begin
                e = sb.pop_front();
                check("data", data_a, e.d);
                check("connected", conn_a, e.c);
                check("pressed", pr_a, e.p);
                check("released", rl_a, e.r);
                check("valid_time", cyc, e.t);
                check("busy_at_valid", busy_a, 1);
                busy_chk = 1;
            end
        end
    end

    int rises_b = 0, run_b = 0, vt_b = -1;
    logic pc_b = 0;
    always @(negedge clk) begin
        if (cclk_b && !pc_b) rises_b++;
        if (cclk_b) run_b++;
        else if (pc_b) begin
            check("b_high_len", run_b, 3);
            run_b = 0;
        end
        pc_b = cclk_b;
        if (valid_b) vt_b = cyc;
    end

    int last_c = -1, rel_cyc = 0, nvalid_c = 0;
    logic first_c = 1;
    always @(negedge clk) begin
        if (rst) begin
            last_c = -1;
            first_c = 1;
        end else if (valid_c) begin
            if (first_c) check("auto_first", cyc - rel_cyc, 70);
            else check("auto_gap", cyc - last_c, 50);
            check("auto_data", {conn_c, data_c}, 0);
            first_c = 0;
            last_c = cyc;
            nvalid_c++;
        end
    end

    task automatic poll_a(input logic [31:0] b, input logic [3:0] pres);
        exp_t e;
        logic [31:0] nd;
        for (int i = 0; i < 4; i++) nd[i*8 +: 8] = pres[i] ? b[i*8 +: 8] : 8'h00;
        btn_a = b;
        pres_a = pres;
        e.d = nd;
        e.c = pres;
        e.p = nd & ~prev_a;
        e.r = ~nd & prev_a;
        prev_a = nd;
        @(negedge clk);
        start_a = 1;
        e.t = cyc + 21;
        sb.push_back(e);
        @(negedge clk);
        start_a = 0;
        check("latch_rise", latch_a, 1);
        check("busy_rise", busy_a, 1);
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            check("valid_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Start requests while the auto-poller is busy, including its valid cycle, must be dropped.
    initial begin
        repeat (300) @(negedge clk);
        for (int k = 0; k < 200 && !busy_c; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        start_c = 1;
        @(negedge clk);
        start_c = 0;
        for (int k = 0; k < 200 && !valid_c; k++) @(negedge clk);
        start_c = 1;
        @(negedge clk);
        start_c = 0;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tb_t;
        repeat (3) @(negedge clk);
        check("rst_ctrl_a", {latch_a, cclk_a, valid_a, busy_a, conn_a}, 0);
        check("rst_data_a", data_a, 0);
        check("rst_edges_a", {pr_a, rl_a}, 0);
        check("rst_ctrl_b", {latch_b, cclk_b, valid_b, busy_b, conn_b}, 0);
        check("rst_data_b", data_b, 0);
        rst = 0;
        rel_cyc = cyc;

        for (int b = 0; b < 256; b++) begin
            logic [7:0] v;
            v = 8'(b);
            poll_a({v + 8'd192, v + 8'd128, v + 8'd64, v}, 4'hF);
        end
        poll_a(32'hFFFF_FFFF, 4'b1101);
        poll_a(32'hFFFF_FF81, 4'hF);
        poll_a(32'hFFFF_FF81, 4'b1110);
        poll_a(32'h0F0F_0F0F, 4'hF);
        poll_a(32'h3C3C_3C3C, 4'hF);
        poll_a(32'h3C3C_3C3C, 4'hF);

        btn_b = {16'h0000, 16'hA55A, 16'hFFFF, 16'h1234};
        rises_b = 0;
        @(negedge clk);
        start_b = 1;
        tb_t = cyc;
        @(negedge clk);
        start_b = 0;
        for (int k = 0; k < 200 && vt_b < 0; k++) @(negedge clk);
        check("b_valid_time", vt_b, tb_t + 105);
        check("b_rises", rises_b, 17);
        check("b_slice2", data_b[47:32], 16'hA55A);
        check("b_data", data_b, 64'h0000_A55A_FFFF_1234);
        check("b_conn", conn_b, 4'hF);

        btn_a = 32'hC3C3_C3C3;
        @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        repeat (3) @(posedge clk);
        #3;
        check("pre_rst_clk", cclk_a, 1);
        rst = 1;
        #1;
        check("mid_rst_ctrl", {latch_a, cclk_a, valid_a, busy_a}, 0);
        check("mid_rst_data", data_a, 0);
        prev_a = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        rel_cyc = cyc;
        repeat (30) @(negedge clk);
        check("post_rst_data", data_a, 0);
        check("post_rst_conn", conn_a, 0);
        poll_a(32'hC3C3_C3C3, 4'hF);
        repeat (200) @(negedge clk);
        check("auto_seen", nvalid_c > 5, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nes_controller_poller.md
# nes_controller_poller

Parametrised successor to the fixed 8-bit NES controller interface: polls up to NUM_CONTROLLERS serial pads sharing one latch/clock pair, in 8-bit (NES) or 16-bit (SNES) mode. Adds a programmable controller-clock rate, optional self-timed auto-polling, per-port connection detection via one extra trailing bit, and per-button press/release edge reporting. Sits between the pad connectors and the input-mapping logic; software-visible state is only updated on a completed poll.

## Interface
- NUM_CONTROLLERS, 4, number of pads sharing latch/clock (1..8)
- DATA_BITS, 8, buttons per pad: 8 (NES) or 16 (SNES)
- LATCH_PULSE_WIDTH, 2, clk cycles controller_latch_o is held high (>=1)
- CLK_HALF_PERIOD, 1, clk cycles per half-period of controller_clk_o (>=1)
- AUTO_POLL_PERIOD, 0, clk cycles between automatic fetch launches; 0 disables
- DETECT, 1, 1 = read one extra bit per poll for connection detection
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start_fetch_i  in  1  request one poll; sampled only while idle
- busy_o  out  1  high from launch cycle until valid_o cycle inclusive
- valid_o  out  1  one-cycle pulse: all outputs below updated this cycle
- controller_clk_o  out  1  shared pad clock, idle low
- controller_latch_o  out  1  shared pad latch
- controller_serial_LIST_ni  in  NUM_CONTROLLERS  active-low serial data, bit i = port i
- data_LIST_o  out  NUM_CONTROLLERS*DATA_BITS  buttons, 1 = pressed; port i at [(i+1)*DATA_BITS-1 : i*DATA_BITS]
- connected_o  out  NUM_CONTROLLERS  1 = pad present on port i
- pressed_LIST_o  out  NUM_CONTROLLERS*DATA_BITS  buttons newly pressed in last poll
- released_LIST_o  out  NUM_CONTROLLERS*DATA_BITS  buttons newly released in last poll

## Operation
- States: IDLE -> LATCH -> LOW -> HIGH -> (LOW | DONE) -> IDLE. N = DATA_BITS + DETECT samples per poll.
- IDLE: latch 0, clk 0. Launch when start_fetch_i=1 or auto-poll tick; both together launch one poll. start_fetch_i during busy is ignored, not queued.
- LATCH: latch 1 for LATCH_PULSE_WIDTH cycles, clk 0.
- LOW: clk 0 for CLK_HALF_PERIOD cycles; on its last cycle sample every serial input (inverted) into that port's shift register, first sample landing in data bit DATA_BITS-1 (MSB first); bit k of the serial stream = data bit DATA_BITS-1-k.
- HIGH: clk 1 for CLK_HALF_PERIOD cycles; then LOW if samples < N, else DONE. N rising edges per poll.
- DONE (one cycle): valid_o=1; commit. With DETECT=1, connected_o[i] = inverted extra sample (connected pad shifts out serial_n=0 after its buttons; pulled-up empty port reads 1). Disconnected port: data forced to 0. DETECT=0: connected_o all 1.
- Edges on commit: pressed = new & ~old, released = ~new & old, per bit; held until next commit. A disconnect therefore reports releases for all previously held buttons.
- Auto-poll: cycle counter runs continuously, wraps at AUTO_POLL_PERIOD-1 and emits a tick; tick while busy is dropped; counter restarts on every launch (manual or auto).
- Serial inputs sampled directly; any metastability synchronisation is external.

## Timing
- Reset (async, immediate): latch 0, controller_clk 0, valid 0, busy 0, data/connected/pressed/released all 0, counter 0, state IDLE. Reset mid-poll aborts with no commit; next poll behaves normally.
- Launch in cycle T (start sampled high): latch rises T+1; valid_o in cycle T + LATCH_PULSE_WIDTH + 2*N*CLK_HALF_PERIOD + 1; busy_o falls the cycle after.
- Defaults (L=2, H=1, N=9): valid_o at T+21. Earliest re-launch: the cycle after valid_o.
- Outputs are registered; stable between valid_o pulses.

## Test plan
- Defaults, 4 pad models, loop buttons 0..255 on all ports -> every data slice equals buttons, connected_o=4'b1111, valid_o exactly T+21.
- DATA_BITS=16, CLK_HALF_PERIOD=3, buttons 16'hA55A on port 2 -> slice 2 = 16'hA55A; 17 rising controller_clk edges, each high 3 cycles.
- Port 1 serial tied high (no pad), others 8'hFF -> connected_o=4'b1101, slice 1 = 0; then removing port 0 after poll with 8'h81 -> released slice 0 = 8'h81.
- Poll 8'h0F then 8'h3C -> pressed = 8'h30, released = 8'h03; third identical poll -> both 0.
- AUTO_POLL_PERIOD=50, start_fetch_i held 0 -> launches every 50 cycles; start_fetch_i pulsed mid-poll -> ignored, no extra valid_o.
- rst pulsed 5 cycles into a poll -> latch/clk/valid low immediately, data stays 0; next start returns correct 8'hC3.
